lsu_bus_ctrl: RTL and testbench

LSU_BUS_CTRL -- requirements
Module: lsu_bus_ctrl

---
 rtl/lsu_bus_ctrl_if.sv | 22 ++
 rtl/lsu_bus_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_lsu_bus_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_bus_ctrl_if.sv
// Bus-side signal bundle of the LSU bus controller.
// master = controller, slave = memory/interconnect.
interface lsu_bus_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit bus controller: IDLE/REQ/WAIT/RESP sequencer with lane steering and load extension.
// Optional access timeout is enabled by defining LSU_TIMEOUT_EN.
module lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  input  logic           req_we,
  input  logic [31:0]    req_addr,
  input  logic [31:0]    req_wdata,
  input  logic [2:0]     req_funct3,
  output logic           busy,
  output logic           rsp_valid,
  output logic [31:0]    rsp_rdata,
  output logic           rsp_err,
  lsu_bus_ctrl_if.master bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  function automatic logic size_illegal(input logic [2:0] f3, input logic we);
    size_illegal = (f3[1:0] == 2'b11) || (f3[2:1] == 2'b11) || (f3[2] && f3[0] && we);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    misaligned = ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

  function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   be_of = 4'b0001 << lo;
      2'b01:   be_of = lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   be_of = 4'b1111;
      default: be_of = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   wdata_of = {4{d[7:0]}};
      2'b01:   wdata_of = {2{d[15:0]}};
      default: wdata_of = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] lo,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lo[1] ? d[31:16] : d[15:0];
    case (f3[1:0])
      2'b00:   load_ext = {{24{b[7] & ~f3[2]}}, b};
      2'b01:   load_ext = {{16{h[15] & ~f3[2]}}, h};
      2'b10:   load_ext = d;
      default: load_ext = 32'd0;
    endcase
  endfunction

  logic [1:0]  state_r, state_s;
  logic        bad_r, bad_s;
  logic [1:0]  lo_r, lo_s;
  logic [2:0]  f3_r, f3_s;
  logic        busy_r, busy_s;
  logic        rsp_valid_r, rsp_valid_s;
  logic [31:0] rsp_rdata_r, rsp_rdata_s;
  logic        rsp_err_r, rsp_err_s;
  logic        bus_req_r, bus_req_s;
  logic        bus_we_r, bus_we_s;
  logic [31:0] bus_addr_r, bus_addr_s;
  logic [31:0] bus_wdata_r, bus_wdata_s;
  logic [3:0]  bus_be_r, bus_be_s;
  logic        tmo_s;

`ifdef LSU_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);
  logic [15:0] cnt_r;

  assign tmo_s = ((state_r == ST_REQ) || (state_r == ST_WAIT)) && (cnt_r == TMO_LAST);

  // Access age counter: held at zero in IDLE so it starts from zero on entry to REQ.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= 16'd0;
    end else if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= 16'd0;
    end
  end
`else
  assign tmo_s = 1'b0;
`endif

  // Next-state and next-output decode; rejected requests spend one bus-silent REQ cycle.
  always_comb begin
    state_s     = state_r;
    bad_s       = bad_r;
    lo_s        = lo_r;
    f3_s        = f3_r;
    bus_req_s   = bus_req_r;
    bus_we_s    = bus_we_r;
    bus_addr_s  = bus_addr_r;
    bus_wdata_s = bus_wdata_r;
    bus_be_s    = bus_be_r;
    rsp_valid_s = 1'b0;
    rsp_err_s   = 1'b0;
    rsp_rdata_s = 32'd0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          bad_s       = size_illegal(req_funct3, req_we) || misaligned(req_funct3, req_addr[1:0]);
          lo_s        = req_addr[1:0];
          f3_s        = req_funct3;
          bus_req_s   = ~bad_s;
          bus_we_s    = req_we;
          bus_addr_s  = {req_addr[31:2], 2'b00};
          bus_wdata_s = wdata_of(req_funct3, req_wdata);
          bus_be_s    = be_of(req_funct3, req_addr[1:0]);
          state_s     = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bad_r || tmo_s) begin
          bus_req_s   = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b1;
          state_s     = ST_RESP;
        end else if (bus.bus_gnt) begin
          bus_req_s = 1'b0;
          state_s   = ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (tmo_s) begin
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b1;
          state_s     = ST_RESP;
        end else if (bus.bus_rvalid) begin
          rsp_valid_s = 1'b1;
          rsp_rdata_s = bus_we_r ? 32'd0 : load_ext(bus.bus_rdata, lo_r, f3_r);
          state_s     = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        bus_req_s = 1'b0;
        state_s   = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      bad_r       <= 1'b0;
      lo_r        <= 2'b00;
      f3_r        <= 3'b000;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_err_r   <= 1'b0;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= 32'd0;
      bus_wdata_r <= 32'd0;
      bus_be_r    <= 4'b0000;
    end else begin
      state_r     <= state_s;
      bad_r       <= bad_s;
      lo_r        <= lo_s;
      f3_r        <= f3_s;
      busy_r      <= busy_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_rdata_r <= rsp_rdata_s;
      rsp_err_r   <= rsp_err_s;
      bus_req_r   <= bus_req_s;
      bus_we_r    <= bus_we_s;
      bus_addr_r  <= bus_addr_s;
      bus_wdata_r <= bus_wdata_s;
      bus_be_r    <= bus_be_s;
    end
  end

  assign busy          = busy_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_rdata     = rsp_rdata_r;
  assign rsp_err       = rsp_err_r;
  assign bus.bus_req   = bus_req_r;
  assign bus.bus_we    = bus_we_r;
  assign bus.bus_addr  = bus_addr_r;
  assign bus.bus_wdata = bus_wdata_r;
  assign bus.bus_be    = bus_be_r;
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl: directed vector table, randomized traffic vs a
// behavioural model, and hand sequences for reset and (with LSU_TIMEOUT_EN) timeout.
module tb_lsu_bus_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        busy, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  lsu_bus_ctrl_if bus_if();

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus(bus_if.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    int          gd;
    int          rd;
    logic [31:0] bdata;
    logic        x_err;
    logic [31:0] x_rdata;
    logic [3:0]  x_be;
    logic [31:0] x_bw;
    int          x_lat;
    int          x_reqc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural model, written directly from the access rules.
  function automatic int m_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic m_err(input logic we, input logic [31:0] a, input logic [2:0] f3);
    if (f3 == 3'b011 || f3[2:1] == 2'b11 || (f3[2] && f3[0] && we)) return 1'b1;
    return (a % m_bytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] f3);
    int n;
    n = m_bytes(f3);
    return 4'(((1 << n) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] w, input logic [2:0] f3);
    logic [31:0] r;
    int n;
    n = m_bytes(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] d, input logic [1:0] lo,
                                          input logic [2:0] f3);
    logic [63:0] mask, v;
    int n;
    n    = m_bytes(f3);
    mask = (64'd1 << (8*n)) - 64'd1;
    v    = ({32'd0, d} >> (8*lo)) & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [31:0] w,
                              input logic [2:0] f3, input int gd, input int rd,
                              input logic [31:0] bd, input logic xe, input logic [31:0] xr,
                              input logic [3:0] xb, input logic [31:0] xw, input int xl,
                              input int xq);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = w; v.f3 = f3; v.gd = gd; v.rd = rd; v.bdata = bd;
    v.x_err = xe; v.x_rdata = xr; v.x_be = xb; v.x_bw = xw; v.x_lat = xl; v.x_reqc = xq;
    return v;
  endfunction

  function automatic vec_t mk_model(input logic we, input logic [31:0] a, input logic [31:0] w,
                                    input logic [2:0] f3, input int gd, input int rd,
                                    input logic [31:0] bd);
    logic e;
    e = m_err(we, a, f3);
    return mk(we, a, w, f3, gd, rd, bd, e,
              (e || we) ? 32'd0 : m_rdata(bd, a[1:0], f3),
              m_be(a, f3), m_wdata(w, f3), e ? 2 : gd + rd + 3, e ? 0 : gd + 1);
  endfunction

  // Drive one access, play the bus slave, and compare everything observed with the record.
  task automatic run_txn(input string tag, input vec_t v);
    int cyc, reqc, waitc, lat;
    bit granted, seen, stable_ok;
    logic [31:0] a0, w0, rd0;
    logic [3:0]  b0;
    logic        we0, er0;
    cyc = 1; reqc = 0; waitc = 0; lat = 0; granted = 0; seen = 0; stable_ok = 1;
    a0 = 32'd0; w0 = 32'd0; b0 = 4'd0; we0 = 1'b0; rd0 = 32'd0; er0 = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_funct3 = v.f3;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    while (!seen && cyc <= 60) begin
      bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = $urandom;
      if (rsp_valid) begin
        seen = 1; lat = cyc; rd0 = rsp_rdata; er0 = rsp_err;
        bus_if.bus_rvalid = 1'b1;
      end else if (bus_if.bus_req) begin
        reqc++;
        if (reqc == 1) begin
          a0 = bus_if.bus_addr; w0 = bus_if.bus_wdata; b0 = bus_if.bus_be; we0 = bus_if.bus_we;
        end else if (a0 !== bus_if.bus_addr || w0 !== bus_if.bus_wdata ||
                     b0 !== bus_if.bus_be || we0 !== bus_if.bus_we) begin
          stable_ok = 0;
        end
        if (reqc > v.gd) begin
          bus_if.bus_gnt = 1'b1;
          granted = 1;
        end
        bus_if.bus_rvalid = 1'($urandom_range(0, 1));
      end else if (granted) begin
        waitc++;
        if (waitc > v.rd) begin
          bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = v.bdata;
        end
      end
      @(posedge clk); #1;
      if (!seen) cyc++;
    end
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_no_rsp: got no rsp_valid within 60 cycles", tag);
    end else begin
      chk({tag, "_lat"}, 32'(lat), 32'(v.x_lat));
      chk({tag, "_err"}, {31'd0, er0}, {31'd0, v.x_err});
      chk({tag, "_rdata"}, rd0, v.x_rdata);
      chk({tag, "_reqcyc"}, 32'(reqc), 32'(v.x_reqc));
      if (!v.x_err) begin
        chk({tag, "_be"}, {28'd0, b0}, {28'd0, v.x_be});
        chk({tag, "_addr"}, a0, v.addr & 32'hFFFF_FFFC);
        chk({tag, "_we"}, {31'd0, we0}, {31'd0, v.we});
        chk({tag, "_stable"}, {31'd0, stable_ok}, 32'd1);
        if (v.we) chk({tag, "_bwdata"}, w0, v.x_bw);
      end
    end
    chk({tag, "_pulse_end"}, {30'd0, rsp_valid, busy}, 32'd0);
  endtask

  task automatic start_access(input logic [31:0] a);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_funct3 = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    bit ok;
    vec_t rv;
    #200000;
    $display("FAIL watchdog: got simulation still running expected $finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    vec_t rv;
    reset = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h104;
    req_wdata = 32'hFFFF_FFFF; req_funct3 = 3'b010;
    bus_if.bus_gnt = 1'b1; bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {27'd0, busy, rsp_valid, rsp_err, bus_if.bus_req, bus_if.bus_we}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_addr", bus_if.bus_addr, 32'd0);
    chk("rst_wdata", bus_if.bus_wdata, 32'd0);
    chk("rst_be", {28'd0, bus_if.bus_be}, 32'd0);
    req_valid = 1'b0; bus_if.bus_gnt = 1'b0;
    reset = 1'b1;
    // rvalid while idle must not produce a response
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_rvalid", {30'd0, rsp_valid, busy}, 32'd0);
    end
    bus_if.bus_rvalid = 1'b0;

    vecs.push_back(mk(0, 32'h100, 32'h0, 3'b010, 0, 0, 32'h8000_00F0, 0, 32'h8000_00F0, 4'hF, 32'h0, 3, 1));
    vecs.push_back(mk(0, 32'h103, 32'h0, 3'b000, 0, 0, 32'h8012_3456, 0, 32'hFFFF_FF80, 4'h8, 32'h0, 3, 1));
    vecs.push_back(mk(0, 32'h103, 32'h0, 3'b100, 0, 0, 32'h8012_3456, 0, 32'h0000_0080, 4'h8, 32'h0, 3, 1));
    vecs.push_back(mk(1, 32'h102, 32'h1234_ABCD, 3'b001, 4, 0, 32'h5555_5555, 0, 32'h0, 4'hC, 32'hABCD_ABCD, 7, 5));
    vecs.push_back(mk(0, 32'h101, 32'h0, 3'b010, 0, 0, 32'h1111_1111, 1, 32'h0, 4'h0, 32'h0, 2, 0));
    vecs.push_back(mk(0, 32'h102, 32'h0, 3'b001, 1, 1, 32'hFFEE_8001, 0, 32'hFFFF_FFEE, 4'hC, 32'h0, 5, 2));
    vecs.push_back(mk(0, 32'h100, 32'h0, 3'b101, 0, 2, 32'h1234_F00F, 0, 32'h0000_F00F, 4'h3, 32'h0, 5, 1));
    vecs.push_back(mk(1, 32'h101, 32'h5A, 3'b000, 1, 2, 32'h0, 0, 32'h0, 4'h2, 32'h5A5A_5A5A, 6, 2));
    vecs.push_back(mk(1, 32'h200, 32'hDEAD_BEEF, 3'b010, 0, 3, 32'h0, 0, 32'h0, 4'hF, 32'hDEAD_BEEF, 6, 1));
    vecs.push_back(mk(0, 32'h100, 32'h0, 3'b011, 0, 0, 32'h0, 1, 32'h0, 4'h0, 32'h0, 2, 0));
    vecs.push_back(mk(1, 32'h100, 32'h0, 3'b101, 0, 0, 32'h0, 1, 32'h0, 4'h0, 32'h0, 2, 0));
    vecs.push_back(mk(0, 32'h0, 32'h0, 3'b110, 0, 0, 32'h0, 1, 32'h0, 4'h0, 32'h0, 2, 0));
    vecs.push_back(mk(0, 32'h103, 32'h0, 3'b001, 0, 0, 32'h0, 1, 32'h0, 4'h0, 32'h0, 2, 0));
    vecs.push_back(mk(0, 32'h101, 32'h0, 3'b000, 0, 0, 32'h0000_7F00, 0, 32'h0000_007F, 4'h2, 32'h0, 3, 1));
    foreach (vecs[i]) run_txn($sformatf("vec%0d", i), vecs[i]);

    for (int i = 0; i < 40; i++) begin
      rv = mk_model(1'($urandom), $urandom, $urandom, 3'($urandom),
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
      run_txn($sformatf("rnd%0d", i), rv);
    end

    // reset while in REQ drops bus_req right after the reset edge
    start_access(32'h300);
    chk("rstreq_pre", {31'd0, bus_if.bus_req}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rstreq_post", {30'd0, bus_if.bus_req, busy}, 32'd0);
    reset = 1'b1;

    // reset while in WAIT abandons the access without a response
    start_access(32'h100);
    bus_if.bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_if.bus_gnt = 1'b0;
    chk("rstwait_pre", {30'd0, busy, bus_if.bus_req}, 32'd2);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rstwait_post", {29'd0, busy, rsp_valid, bus_if.bus_req}, 32'd0);
    reset = 1'b1; bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus_if.bus_rvalid = 1'b0;
    chk("rstwait_late", {30'd0, busy, rsp_valid}, 32'd0);
    run_txn("post_rst_lw", mk(0, 32'h100, 32'h0, 3'b010, 0, 0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 4'hF, 32'h0, 3, 1));

`ifdef LSU_TIMEOUT_EN
    // no rvalid: error response after 8 REQ/WAIT cycles, late rvalid ignored
    start_access(32'h100);
    bus_if.bus_gnt = 1'b1;
    ok = 0;
    for (int c = 1; c <= 20 && !ok; c++) begin
      if (rsp_valid) begin
        ok = 1;
        chk("tmo_lat", 32'(c), 32'd9);
        chk("tmo_err", {31'd0, rsp_err}, 32'd1);
        chk("tmo_rdata", rsp_rdata, 32'd0);
      end else begin
        @(posedge clk); #1;
        bus_if.bus_gnt = 1'b0;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL tmo_no_rsp: got no rsp_valid expected timeout response");
    end
    bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'hAAAA_AAAA;
    @(posedge clk); #1;
    bus_if.bus_rvalid = 1'b0;
    chk("tmo_late_rvalid", {30'd0, busy, rsp_valid}, 32'd0);
`else
    // without the timeout the access waits indefinitely for rvalid
    start_access(32'h100);
    bus_if.bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_if.bus_gnt = 1'b0;
    ok = 1;
    repeat (30) begin
      if (rsp_valid || !busy) ok = 0;
      @(posedge clk); #1;
    end
    chk("notmo_wait", {31'd0, ok}, 32'd1);
    bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    bus_if.bus_rvalid = 1'b0;
    chk("notmo_rsp", {30'd0, rsp_valid, rsp_err}, 32'd2);
    chk("notmo_rdata", rsp_rdata, 32'h0BAD_F00D);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
